// File: rtl/instr_buf_pkg.sv
// Shared types and constants for the instruction buffer read side.
// Provides the reader FSM state encoding and the index-width helper.
package instr_buf_pkg;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      LOAD  = 2'd1,
      OFFER = 2'd2
   } state_t;

   localparam int RR_START_RESET = 0;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of bitmap at or after start, wrapping.
// Rotates the bitmap so start lands at position 0, priority-encodes, then un-rotates.
module rr_priority_picker
   import instr_buf_pkg::*;
#(
   parameter int BS = 16,
   parameter int IW = idx_width(BS)
) (
   input  logic [0:BS-1] bitmap,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [0:BS-1] rot;
   logic [IW-1:0] off;

   always_comb begin
      rot = '0;
      for (int j = 0; j < BS; j++) begin
         rot[j] = bitmap[start + IW'(j)];
      end
   end

   // Descending loop so the lowest rotated position wins.
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int j = BS - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = IW'(j);
         end
      end
   end

   // BS is a power of two, so the IW-bit add wraps modulo BS.
   assign index = start + off;

endmodule

// File: rtl/instr_buffer_reader.sv
// Drains valid instruction-buffer entries in round-robin order and offers them downstream.
// Handshake: instr_out transfers on a rising edge where instr_valid & instr_ready; once raised, instr_valid and instr_out hold until that transfer (or flush/reset).
module instr_buffer_reader
   import instr_buf_pkg::*;
#(
   parameter int Instruction_word_size = 32,
   parameter int bs = 16,
   parameter int IW = idx_width(bs)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [0:bs-1]                    valid_entries,
   input  logic                             flush,
   output logic [IW-1:0]                    rd_index,
   input  logic [Instruction_word_size-1:0] rd_data,
   output logic [Instruction_word_size-1:0] instr_out,
   output logic                             instr_valid,
   input  logic                             instr_ready,
   output logic                             clr_en,
   output logic [IW-1:0]                    clr_index,
   output logic [1:0]                       state,
   output logic [IW-1:0]                    ptr
);

   state_t          cur_state;
   state_t          nxt_state;
   logic            pick_found;
   logic [IW-1:0]   pick_index;
   logic            data_live;

   rr_priority_picker #(.BS(bs), .IW(IW)) u_picker (
      .bitmap (valid_entries),
      .start  (ptr),
      .found  (pick_found),
      .index  (pick_index)
   );

   assign data_live = (rd_data != '0);
   assign state     = cur_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= SCAN;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      if (flush) begin
         nxt_state = SCAN;
      end else begin
         case (cur_state)
            SCAN:    if (pick_found) nxt_state = LOAD;
            LOAD:    nxt_state = data_live ? OFFER : SCAN;
            OFFER:   if (instr_ready) nxt_state = SCAN;
            default: nxt_state = SCAN;
         endcase
      end
   end

   // The clear is issued while the entry is being captured; flush cancels it.
   always_comb begin
      clr_en    = 1'b0;
      clr_index = '0;
      if (cur_state == LOAD && !flush) begin
         clr_en    = 1'b1;
         clr_index = rd_index;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= IW'(RR_START_RESET);
         rd_index    <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
      end else if (flush) begin
         ptr         <= IW'(RR_START_RESET);
         instr_valid <= 1'b0;
      end else begin
         case (cur_state)
            SCAN: begin
               if (pick_found) rd_index <= pick_index;
            end
            LOAD: begin
               // A zero word means the entry was overwritten after the scan.
               if (data_live) begin
                  instr_out   <= rd_data;
                  instr_valid <= 1'b1;
               end else begin
                  ptr <= rd_index + 1'b1;
               end
            end
            OFFER: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  ptr         <= rd_index + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_buffer_reader.sv
// Directed bench for instr_buffer_reader with a small behavioural buffer memory.
// Steps are linear; each check is an immediate assertion that counts failures.
module tb_instr_buffer_reader;

   logic        clk;
   logic        rst;
   logic [0:15] valid_entries;
   logic        flush;
   logic [3:0]  rd_index;
   logic [31:0] rd_data;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        clr_en;
   logic [3:0]  clr_index;
   logic [1:0]  state;
   logic [3:0]  ptr;

   logic [31:0] mem [0:15];
   int          tests;
   int          fails;

   instr_buffer_reader #(.Instruction_word_size(32), .bs(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_entries (valid_entries),
      .flush         (flush),
      .rd_index      (rd_index),
      .rd_data       (rd_data),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .clr_en        (clr_en),
      .clr_index     (clr_index),
      .state         (state),
      .ptr           (ptr)
   );

   assign rd_data = mem[rd_index];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits a bounded number of cycles for an offer, checks it, then lets the handshake happen.
   task automatic get_issue(input string tag, input logic [31:0] exp);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         step();
         if (instr_valid) seen = 1'b1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_data"}, instr_out, exp);
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      flush = 1'b0;
      valid_entries = '0;
      instr_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Reset values
      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ptr", 32'(ptr), 32'd0);
      chk("rst_rd_index", 32'(rd_index), 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_clr", 32'({clr_en, clr_index}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Empty bitmap
      for (int i = 0; i < 20; i++) begin
         step();
         chk("empty", 32'({instr_valid, clr_en, rd_index}), 32'd0);
      end

      // Single entry 5
      mem[5] = 32'hDEAD_BEEF;
      valid_entries[5] = 1'b1;
      instr_ready = 1'b1;
      step();
      chk("single_state_load", 32'(state), 32'd1);
      chk("single_rd_index", 32'(rd_index), 32'd5);
      chk("single_clr", 32'({clr_en, clr_index}), 32'h15);
      chk("single_valid_early", 32'(instr_valid), 32'd0);
      valid_entries[5] = 1'b0;
      step();
      chk("single_valid", 32'(instr_valid), 32'd1);
      chk("single_data", instr_out, 32'hDEAD_BEEF);
      chk("single_no_clr", 32'(clr_en), 32'd0);
      step();
      chk("single_done_state", 32'(state), 32'd0);
      chk("single_done_valid", 32'(instr_valid), 32'd0);
      chk("single_ptr", 32'(ptr), 32'd6);

      // Flush in SCAN returns ptr to 0
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_scan_ptr", 32'(ptr), 32'd0);

      // Round robin 2, 9, 14, then 2 again with the bitmap held
      mem[2] = 32'h0000_0222;
      mem[9] = 32'h0000_0999;
      mem[14] = 32'h0000_0EEE;
      valid_entries = '0;
      valid_entries[2] = 1'b1;
      valid_entries[9] = 1'b1;
      valid_entries[14] = 1'b1;
      get_issue("rr_a", 32'h0000_0222);
      get_issue("rr_b", 32'h0000_0999);
      get_issue("rr_c", 32'h0000_0EEE);
      get_issue("rr_d", 32'h0000_0222);
      chk("rr_ptr", 32'(ptr), 32'd3);

      // Wrap: move ptr to 15, then only entry 3 valid
      valid_entries = '0;
      valid_entries[14] = 1'b1;
      get_issue("to15", 32'h0000_0EEE);
      chk("ptr15", 32'(ptr), 32'd15);
      mem[3] = 32'h0000_0333;
      valid_entries = '0;
      valid_entries[3] = 1'b1;
      get_issue("wrap", 32'h0000_0333);
      chk("wrap_ptr", 32'(ptr), 32'd4);

      // Backpressure on entry 10
      valid_entries = '0;
      valid_entries[10] = 1'b1;
      mem[10] = 32'hA0A0_A0A0;
      instr_ready = 1'b0;
      step();
      chk("bp_clr", 32'({clr_en, clr_index}), 32'h1A);
      valid_entries = '0;
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_data", instr_out, 32'hA0A0_A0A0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("bp_hold_valid", 32'(instr_valid), 32'd1);
         chk("bp_hold_data", instr_out, 32'hA0A0_A0A0);
         chk("bp_hold_clr", 32'(clr_en), 32'd0);
         chk("bp_hold_state", 32'(state), 32'd2);
      end
      instr_ready = 1'b1;
      step();
      chk("bp_done_state", 32'(state), 32'd0);
      chk("bp_done_valid", 32'(instr_valid), 32'd0);
      chk("bp_ptr", 32'(ptr), 32'd11);

      // Stale entry 7 (data zero), scan resumes from 8
      valid_entries[7] = 1'b1;
      mem[7] = 32'd0;
      step();
      chk("stale_rd_index", 32'(rd_index), 32'd7);
      chk("stale_clr", 32'({clr_en, clr_index}), 32'h17);
      step();
      chk("stale_state", 32'(state), 32'd0);
      chk("stale_valid", 32'(instr_valid), 32'd0);
      chk("stale_ptr", 32'(ptr), 32'd8);
      mem[7] = 32'h0000_0777;
      mem[8] = 32'h0000_0888;
      valid_entries[8] = 1'b1;
      get_issue("after_stale", 32'h0000_0888);
      valid_entries = '0;

      // Flush during OFFER
      instr_ready = 1'b0;
      mem[12] = 32'h0000_000C;
      valid_entries[12] = 1'b1;
      step();
      valid_entries = '0;
      step();
      chk("fo_valid_before", 32'(instr_valid), 32'd1);
      flush = 1'b1;
      instr_ready = 1'b1;
      step();
      flush = 1'b0;
      chk("fo_valid", 32'(instr_valid), 32'd0);
      chk("fo_ptr", 32'(ptr), 32'd0);
      chk("fo_state", 32'(state), 32'd0);

      // Flush coinciding with LOAD suppresses the clear
      mem[1] = 32'h0000_0111;
      valid_entries[1] = 1'b1;
      step();
      chk("fl_load_clr_on", 32'(clr_en), 32'd1);
      flush = 1'b1;
      #1;
      chk("fl_load_clr_off", 32'(clr_en), 32'd0);
      step();
      flush = 1'b0;
      valid_entries = '0;
      chk("fl_load_state", 32'(state), 32'd0);
      chk("fl_load_valid", 32'(instr_valid), 32'd0);

      // Asynchronous reset during LOAD
      mem[4] = 32'h0000_0444;
      valid_entries[4] = 1'b1;
      step();
      chk("ar_load_clr", 32'({clr_en, clr_index}), 32'h14);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_state", 32'(state), 32'd0);
      chk("ar_rd_index", 32'(rd_index), 32'd0);
      chk("ar_instr_out", instr_out, 32'd0);
      chk("ar_valid", 32'(instr_valid), 32'd0);
      chk("ar_clr", 32'({clr_en, clr_index}), 32'd0);
      #1;
      rst = 1'b0;
      valid_entries = '0;
      step();
      chk("ar_after_state", 32'(state), 32'd0);
      chk("ar_after_clr", 32'(clr_en), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
